place_cost_eval: RTL
====================

PLACE_COST_EVAL -- requirements
Module: place_cost_eval

Interface
REQ-001 SHALL have parameter N_EDGE, default 52: number of edges evaluated per run (1..2^EDGE_AW).
REQ-002 SHALL have parameter EDGE_AW, default 8: edge-memory address width.
REQ-003 SHALL have parameter NODE_AW, default 7: node-id and position-memory address width.
REQ-004 SHALL have parameter COORD_W, default 32: signed coordinate width; value -1 means unplaced.
REQ-005 SHALL have parameter SUM_W, default 32: signed accumulator width.
REQ-006 SHALL have parameter HOP, default 2: cells per hop, one of 1, 2, 4, 8.
REQ-007 SHALL have parameter MEM_LAT, default 1: read latency in cycles, 1 or 2, applying to both memories.
REQ-008 Ports (name dir width meaning): clk in 1 clock; reset in 1 asynchronous active-low reset; start in 1 run request; busy out 1 run active; done out 1 one-cycle end pulse.
REQ-009 Ports: edge_re out 1 edge read strobe; edge_addr out EDGE_AW edge index; edge_a in NODE_AW source node; edge_b in NODE_AW sink node.
REQ-010 Ports: pos_re out 1 position read strobe; pos_addr out NODE_AW node id; pos_x in COORD_W x; pos_y in COORD_W y.
REQ-011 Ports: sum out SUM_W Manhattan cost; sum_hop out SUM_W hop cost; overlap out 16 count of zero-distance edges; unplaced out 1 sticky error; cycles out 32 run cycle count.

Function
REQ-012 FSM states SHALL be IDLE, RD_EDGE, WT_EDGE, RD_A, WT_A, RD_B, WT_B, CALC, ACC, FIN.
REQ-013 IDLE: start=1 -> clear sum, sum_hop, overlap, unplaced, cycles, edge index; busy<=1; go to RD_EDGE. start=0 -> stay.
REQ-014 start asserted while busy=1 SHALL be ignored.
REQ-015 RD_EDGE: edge index = N_EDGE -> FIN; else pulse edge_re one cycle with edge_addr=index, go to WT_EDGE.
REQ-016 WT_x states SHALL wait exactly MEM_LAT cycles after the strobe, then latch the input data.
REQ-017 RD_A reads position of latched edge_a; RD_B reads position of latched edge_b; each uses a single-cycle pos_re pulse.
REQ-018 CALC: dx=|xa-xb|, dy=|ya-yb| in COORD_W+1 bits, no overflow.
REQ-019 ACC: d=dx+dy; d>0 -> sum += d-1 and sum_hop += ceil(dx/HOP)+ceil(dy/HOP)-1; d=0 -> overlap++ (saturating at 16'hFFFF) and no cost added.
REQ-020 ceil(v/HOP) SHALL be computed as (v>>log2 HOP) plus 1 if any low bit is set; no divider.
REQ-021 If any of xa, ya, xb, yb equals -1, the edge SHALL be skipped in ACC (no cost, no overlap), unplaced<=1 (sticky until next start).
REQ-022 ACC SHALL increment the edge index and return to RD_EDGE.
REQ-023 FIN: done=1 for exactly one cycle, busy<=0, -> IDLE; sum, sum_hop, overlap, unplaced, cycles hold until next start.
REQ-024 cycles SHALL increment every clock while busy=1, saturating at all-ones.
REQ-025 edge_re and pos_re SHALL never be asserted in the same cycle.
REQ-026 Per-edge latency SHALL be exactly 7+3*MEM_LAT cycles; a run takes N_EDGE*(7+3*MEM_LAT)+3 cycles from start to done.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, edge_re=0, pos_re=0, edge_addr=0, pos_addr=0, sum=0, sum_hop=0, overlap=0, unplaced=0, cycles=0.
REQ-028 Reset during a run SHALL abort it without a done pulse; the first start after release begins a clean run.

Configuration
REQ-029 Macro PLACE_COST_MAXLEN_EN defined: adds outputs max_len (COORD_W+1) and max_edge (EDGE_AW), the largest d seen and its first edge index; both cleared on start and on reset; skipped edges are excluded.
REQ-030 Macro PLACE_COST_MAXLEN_EN undefined: those ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Single edge A=(0,0), B=(3,5), HOP=2 -> sum=7, sum_hop=4, overlap=0, done after 13 cycles (MEM_LAT=1).
REQ-032 Edge with both nodes at (2,2) -> overlap=1, sum=0, sum_hop=0.
REQ-033 Edge with B at x=-1 -> unplaced=1, sum unchanged, run completes with done.
REQ-034 start pulsed again mid-run -> no restart; results equal an uninterrupted run.
REQ-035 reset=0 at edge 10 of 52 -> all outputs 0, no done; next start gives full correct totals.
REQ-036 With PLACE_COST_MAXLEN_EN, edges d=4,9,9,2 -> max_len=9, max_edge=1.

Source files
------------

// File: rtl/place_cost_eval_if.sv
// place_cost_eval_if
//   Bundles the run-control handshake, the edge/position memory read buses
//   and the result outputs of place_cost_eval.
//   slave  : the evaluator side (drives strobes, addresses and results)
//   master : the host/memory side (drives start and read data)
// Optional macro PLACE_COST_MAXLEN_EN adds max_len / max_edge.
interface place_cost_eval_if #(
    parameter int EDGE_AW = 8,
    parameter int NODE_AW = 7,
    parameter int COORD_W = 32,
    parameter int SUM_W   = 32
);
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      edge_re;
    logic [EDGE_AW-1:0]        edge_addr;
    logic [NODE_AW-1:0]        edge_a;
    logic [NODE_AW-1:0]        edge_b;
    logic                      pos_re;
    logic [NODE_AW-1:0]        pos_addr;
    logic signed [COORD_W-1:0] pos_x;
    logic signed [COORD_W-1:0] pos_y;
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   sum_hop;
    logic [15:0]               overlap;
    logic                      unplaced;
    logic [31:0]               cycles;
`ifdef PLACE_COST_MAXLEN_EN
    logic [COORD_W:0]          max_len;
    logic [EDGE_AW-1:0]        max_edge;

    modport slave (
        input  start, edge_a, edge_b, pos_x, pos_y,
        output busy, done, edge_re, edge_addr, pos_re, pos_addr,
        output sum, sum_hop, overlap, unplaced, cycles, max_len, max_edge
    );
    modport master (
        output start, edge_a, edge_b, pos_x, pos_y,
        input  busy, done, edge_re, edge_addr, pos_re, pos_addr,
        input  sum, sum_hop, overlap, unplaced, cycles, max_len, max_edge
    );
`else
    modport slave (
        input  start, edge_a, edge_b, pos_x, pos_y,
        output busy, done, edge_re, edge_addr, pos_re, pos_addr,
        output sum, sum_hop, overlap, unplaced, cycles
    );
    modport master (
        output start, edge_a, edge_b, pos_x, pos_y,
        input  busy, done, edge_re, edge_addr, pos_re, pos_addr,
        input  sum, sum_hop, overlap, unplaced, cycles
    );
`endif
endinterface

// File: rtl/place_cost_eval.sv
// place_cost_eval
//   Walks N_EDGE edges of a placed netlist, fetches both endpoint positions
//   and accumulates Manhattan wirelength (d-1 per edge), hop cost and the
//   number of zero-length edges. Edges touching an unplaced node (-1 coord)
//   are skipped and flag the sticky unplaced error.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : place_cost_eval_if.slave
//           start/busy/done        run control (done = one-cycle pulse)
//           edge_re/edge_addr/edge_a/edge_b  edge memory read
//           pos_re/pos_addr/pos_x/pos_y      position memory read
//           sum/sum_hop/overlap/unplaced/cycles  results, held after done
// Optional macro PLACE_COST_MAXLEN_EN: adds max_len/max_edge tracking.
//
// state   | meaning
// IDLE    | waiting for start, results held
// RD_EDGE | end check; edge_re asserted for current index
// WT_EDGE | wait MEM_LAT cycles, latch edge endpoints
// RD_A    | launch position read for source node
// WT_A    | strobe cycle + MEM_LAT cycles, latch source position
// RD_B    | launch position read for sink node
// WT_B    | strobe cycle + MEM_LAT cycles, latch sink position
// CALC    | absolute dx/dy and unplaced detect
// ACC     | update accumulators, advance edge index
// FIN     | one-cycle done, drop busy
module place_cost_eval #(
    parameter int N_EDGE  = 52,
    parameter int EDGE_AW = 8,
    parameter int NODE_AW = 7,
    parameter int COORD_W = 32,
    parameter int SUM_W   = 32,
    parameter int HOP     = 2,
    parameter int MEM_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    place_cost_eval_if.slave bus
);
    localparam int SH    = (HOP == 8) ? 3 : (HOP == 4) ? 2 : (HOP == 2) ? 1 : 0;
    localparam int IDX_W = EDGE_AW + 1;
    localparam int DW    = COORD_W + 1;
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(N_EDGE);
    localparam logic [DW-1:0]    LOW_MASK  = DW'((1 << SH) - 1);
    // edge_re is a decode of RD_EDGE, so the strobe is already on the wire
    // in RD_EDGE; pos_re is registered, so its strobe lands in the first
    // WT_A/WT_B cycle and those states last one cycle longer.
    localparam logic [1:0]       EDGE_LAST = 2'(MEM_LAT - 1);
    localparam logic [1:0]       POS_LAST  = 2'(MEM_LAT);

    typedef enum logic [3:0] {
        IDLE, RD_EDGE, WT_EDGE, RD_A, WT_A, RD_B, WT_B, CALC, ACC, FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [1:0]                wait_cnt_q, wait_cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      pos_re_q, pos_re_d;
    logic [NODE_AW-1:0]        pos_addr_q, pos_addr_d;
    logic [NODE_AW-1:0]        node_a_q, node_a_d;
    logic [NODE_AW-1:0]        node_b_q, node_b_d;
    logic [COORD_W-1:0]        xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
    logic [DW-1:0]             dx_q, dx_d, dy_q, dy_d;
    logic                      skip_q, skip_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [SUM_W-1:0]          hop_q, hop_d;
    logic [15:0]               overlap_q, overlap_d;
    logic                      unplaced_q, unplaced_d;
    logic [31:0]               cycles_q, cycles_d;

    logic [DW-1:0]             diff_x, diff_y, abs_x, abs_y;
    logic [DW:0]               d_len, hop_inc;
    logic [DW-1:0]             ceil_x, ceil_y;

    function automatic logic [DW-1:0] ceil_hop(input logic [DW-1:0] v);
        logic [DW-1:0] q;
        q = v >> SH;
        if ((v & LOW_MASK) != '0) begin
            q = q + 1'b1;
        end
        return q;
    endfunction

    // Sign-extend by one bit so the difference of any two coordinates fits.
    assign diff_x  = {xa_q[COORD_W-1], xa_q} - {xb_q[COORD_W-1], xb_q};
    assign diff_y  = {ya_q[COORD_W-1], ya_q} - {yb_q[COORD_W-1], yb_q};
    assign abs_x   = diff_x[DW-1] ? (~diff_x + 1'b1) : diff_x;
    assign abs_y   = diff_y[DW-1] ? (~diff_y + 1'b1) : diff_y;

    assign d_len   = {1'b0, dx_q} + {1'b0, dy_q};
    assign ceil_x  = ceil_hop(dx_q);
    assign ceil_y  = ceil_hop(dy_q);
    assign hop_inc = {1'b0, ceil_x} + {1'b0, ceil_y} - {{DW{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pos_re_d   = 1'b0;
        pos_addr_d = pos_addr_q;
        node_a_d   = node_a_q;
        node_b_d   = node_b_q;
        xa_d       = xa_q;
        ya_d       = ya_q;
        xb_d       = xb_q;
        yb_d       = yb_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        skip_d     = skip_q;
        sum_d      = sum_q;
        hop_d      = hop_q;
        overlap_d  = overlap_q;
        unplaced_d = unplaced_q;
        cycles_d   = (busy_q && !(&cycles_q)) ? cycles_q + 32'd1 : cycles_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sum_d      = '0;
                    hop_d      = '0;
                    overlap_d  = '0;
                    unplaced_d = 1'b0;
                    cycles_d   = '0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = RD_EDGE;
                end
            end
            RD_EDGE: begin
                if (idx_q == IDX_END) begin
                    state_d = FIN;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = WT_EDGE;
                end
            end
            WT_EDGE: begin
                if (wait_cnt_q == EDGE_LAST) begin
                    node_a_d = bus.edge_a;
                    node_b_d = bus.edge_b;
                    state_d  = RD_A;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            RD_A: begin
                pos_re_d   = 1'b1;
                pos_addr_d = node_a_q;
                wait_cnt_d = '0;
                state_d    = WT_A;
            end
            WT_A: begin
                if (wait_cnt_q == POS_LAST) begin
                    xa_d    = bus.pos_x;
                    ya_d    = bus.pos_y;
                    state_d = RD_B;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            RD_B: begin
                pos_re_d   = 1'b1;
                pos_addr_d = node_b_q;
                wait_cnt_d = '0;
                state_d    = WT_B;
            end
            WT_B: begin
                if (wait_cnt_q == POS_LAST) begin
                    xb_d    = bus.pos_x;
                    yb_d    = bus.pos_y;
                    state_d = CALC;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            CALC: begin
                dx_d    = abs_x;
                dy_d    = abs_y;
                skip_d  = (&xa_q) || (&ya_q) || (&xb_q) || (&yb_q);
                state_d = ACC;
            end
            ACC: begin
                if (skip_q) begin
                    unplaced_d = 1'b1;
                end else if (d_len == '0) begin
                    if (overlap_q != 16'hFFFF) begin
                        overlap_d = overlap_q + 16'd1;
                    end
                end else begin
                    sum_d = sum_q + SUM_W'(d_len - 1'b1);
                    hop_d = hop_q + SUM_W'(hop_inc);
                end
                idx_d   = idx_q + 1'b1;
                state_d = RD_EDGE;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pos_re_q   <= 1'b0;
            pos_addr_q <= '0;
            node_a_q   <= '0;
            node_b_q   <= '0;
            xa_q       <= '0;
            ya_q       <= '0;
            xb_q       <= '0;
            yb_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            skip_q     <= 1'b0;
            sum_q      <= '0;
            hop_q      <= '0;
            overlap_q  <= '0;
            unplaced_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pos_re_q   <= pos_re_d;
            pos_addr_q <= pos_addr_d;
            node_a_q   <= node_a_d;
            node_b_q   <= node_b_d;
            xa_q       <= xa_d;
            ya_q       <= ya_d;
            xb_q       <= xb_d;
            yb_q       <= yb_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            skip_q     <= skip_d;
            sum_q      <= sum_d;
            hop_q      <= hop_d;
            overlap_q  <= overlap_d;
            unplaced_q <= unplaced_d;
            cycles_q   <= cycles_d;
        end
    end

`ifdef PLACE_COST_MAXLEN_EN
    logic [DW-1:0]      max_len_q, max_len_d;
    logic [EDGE_AW-1:0] max_edge_q, max_edge_d;

    // Strict compare keeps the first edge that reached the maximum.
    always_comb begin
        max_len_d  = max_len_q;
        max_edge_d = max_edge_q;
        if (state_q == IDLE && bus.start) begin
            max_len_d  = '0;
            max_edge_d = '0;
        end else if (state_q == ACC && !skip_q && (d_len > {1'b0, max_len_q})) begin
            max_len_d  = DW'(d_len);
            max_edge_d = idx_q[EDGE_AW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_len_q  <= '0;
            max_edge_q <= '0;
        end else begin
            max_len_q  <= max_len_d;
            max_edge_q <= max_edge_d;
        end
    end

    assign bus.max_len  = max_len_q;
    assign bus.max_edge = max_edge_q;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.edge_re   = (state_q == RD_EDGE) && (idx_q != IDX_END);
    assign bus.edge_addr = idx_q[EDGE_AW-1:0];
    assign bus.pos_re    = pos_re_q;
    assign bus.pos_addr  = pos_addr_q;
    assign bus.sum       = sum_q;
    assign bus.sum_hop   = hop_q;
    assign bus.overlap   = overlap_q;
    assign bus.unplaced  = unplaced_q;
    assign bus.cycles    = cycles_q;
endmodule
